// File: rtl/fnd_scan_decoder.sv
// Receive-side decoder for a multiplexed 4-digit active-low FND bus.
// Samples each settled digit, decodes the segments back to BCD, collects complete
// scans, requires MATCH_SCANS identical scans, then converts the BCD to binary
// and publishes it with a one-cycle valid pulse.
module fnd_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES = 4,  // 1..255
  parameter int unsigned MATCH_SCANS   = 2   // 1..7
) (
  input  logic        clk,
  input  logic        rst,         // asynchronous, active-low
  input  logic [3:0]  i_fnd_com,
  input  logic [7:0]  i_fnd_data,
  output logic [13:0] o_value,
  output logic [15:0] o_digits,
  output logic        o_valid,
  output logic        o_err
);

  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);
  localparam logic [2:0] MatchMax   = 3'(MATCH_SCANS);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e      state_q, state_d;

  logic [3:0]  com_meta_q, com_sync_q, com_prev_q;
  logic [7:0]  data_meta_q, data_sync_q;
  logic [7:0]  settle_q, settle_d;
  logic        sampled_q, sampled_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] scan_q, scan_d;
  logic [15:0] prev_snap_q;
  logic [2:0]  match_q, match_d;
  logic        published_q, published_d;
  logic [15:0] conv_q, conv_d;
  logic [13:0] acc_q, acc_d;
  logic [1:0]  idx_q, idx_d;
  logic [13:0] value_d;
  logic [15:0] digits_d;
  logic        valid_d, err_d;

  logic [3:0]  slot_oh;
  logic        com_valid, com_stable, do_sample;
  logic [3:0]  dec_digit;
  logic        dec_ok;
  logic        scan_done, trigger;
  logic [3:0]  cur_digit;

  // Digit-select decode: one-hot-low codes map to scan slots, anything else is idle
  always_comb begin
    slot_oh = 4'b0000;
    case (com_sync_q)
      4'b1110: slot_oh = 4'b0001;  // ones
      4'b1101: slot_oh = 4'b0010;  // tens
      4'b1011: slot_oh = 4'b0100;  // hundreds
      4'b0111: slot_oh = 4'b1000;  // thousands
      default: slot_oh = 4'b0000;
    endcase
    com_valid  = |slot_oh;
    com_stable = com_valid && (com_sync_q == com_prev_q);
  end

  // Settle counter: counts cycles the same valid code has been held, one sample per dwell
  always_comb begin
    settle_d  = 8'd0;
    sampled_d = 1'b0;
    do_sample = 1'b0;
    if (com_valid) begin
      if (com_stable) begin
        settle_d  = (settle_q == 8'hFF) ? settle_q : settle_q + 8'd1;
        sampled_d = sampled_q;
      end
      if ((settle_d == SettleLast) && !sampled_d) begin
        do_sample = 1'b1;
        sampled_d = 1'b1;
      end
    end
  end

  // Segment pattern to BCD, exact 8-bit match only
  always_comb begin
    dec_digit = 4'd0;
    dec_ok    = 1'b1;
    case (data_sync_q)
      8'hC0: dec_digit = 4'd0;
      8'hF9: dec_digit = 4'd1;
      8'hA4: dec_digit = 4'd2;
      8'hB0: dec_digit = 4'd3;
      8'h99: dec_digit = 4'd4;
      8'h92: dec_digit = 4'd5;
      8'h82: dec_digit = 4'd6;
      8'hF8: dec_digit = 4'd7;
      8'h80: dec_digit = 4'd8;
      8'h90: dec_digit = 4'd9;
      default: dec_ok = 1'b0;
    endcase
  end

  // Scan collection, snapshot matching and publish trigger
  always_comb begin
    scan_d    = scan_q;
    mask_d    = mask_q;
    match_d   = match_q;
    err_d     = 1'b0;
    scan_done = 1'b0;
    if (do_sample) begin
      if (!dec_ok) begin
        err_d   = 1'b1;
        mask_d  = 4'b0000;
        match_d = 3'd0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (slot_oh[i]) scan_d[4*i +: 4] = dec_digit;
        end
        mask_d = mask_q | slot_oh;
        if (mask_d == 4'b1111) begin
          scan_done = 1'b1;
          mask_d    = 4'b0000;
          if (scan_d == prev_snap_q) begin
            match_d = (match_q >= MatchMax) ? MatchMax : match_q + 3'd1;
          end else begin
            match_d = 3'd1;
          end
        end
      end
    end
    trigger = scan_done && (match_d == MatchMax) && (!published_q || (scan_d != o_digits));
  end

  // Current BCD digit for conversion, thousands first
  always_comb begin
    unique case (idx_q)
      2'd0: cur_digit = conv_q[15:12];
      2'd1: cur_digit = conv_q[11:8];
      2'd2: cur_digit = conv_q[7:4];
      2'd3: cur_digit = conv_q[3:0];
    endcase
  end

  // FSM next state and conversion datapath
  always_comb begin
    state_d     = state_q;
    conv_d      = conv_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    value_d     = o_value;
    digits_d    = o_digits;
    valid_d     = 1'b0;
    published_d = published_q;
    case (state_q)
      StIdle: begin
        if (trigger) begin
          conv_d  = scan_d;
          acc_d   = 14'd0;
          idx_d   = 2'd0;
          state_d = StConv;
        end
      end
      StConv: begin
        acc_d = (acc_q << 3) + (acc_q << 1) + {10'd0, cur_digit};
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = StDone;
      end
      StDone: begin
        value_d     = acc_q;
        digits_d    = conv_q;
        valid_d     = 1'b1;
        published_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Synchronizers, scan state, conversion registers and outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      com_meta_q  <= 4'd0;
      com_sync_q  <= 4'd0;
      com_prev_q  <= 4'd0;
      data_meta_q <= 8'd0;
      data_sync_q <= 8'd0;
      settle_q    <= 8'd0;
      sampled_q   <= 1'b0;
      mask_q      <= 4'd0;
      scan_q      <= 16'd0;
      prev_snap_q <= 16'd0;
      match_q     <= 3'd0;
      published_q <= 1'b0;
      conv_q      <= 16'd0;
      acc_q       <= 14'd0;
      idx_q       <= 2'd0;
      o_value     <= 14'd0;
      o_digits    <= 16'd0;
      o_valid     <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      com_meta_q  <= i_fnd_com;
      com_sync_q  <= com_meta_q;
      com_prev_q  <= com_sync_q;
      data_meta_q <= i_fnd_data;
      data_sync_q <= data_meta_q;
      settle_q    <= settle_d;
      sampled_q   <= sampled_d;
      mask_q      <= mask_d;
      scan_q      <= scan_d;
      if (scan_done) prev_snap_q <= scan_d;
      match_q     <= match_d;
      published_q <= published_d;
      conv_q      <= conv_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      o_value     <= value_d;
      o_digits    <= digits_d;
      o_valid     <= valid_d;
      o_err       <= err_d;
    end
  end

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed bench for fnd_scan_decoder: drives scanned FND patterns and checks
// published values, pulse counts and reset behaviour.
module tb_fnd_scan_decoder;

  logic        clk;
  logic        rst;
  logic [3:0]  i_fnd_com;
  logic [7:0]  i_fnd_data;
  logic [13:0] o_value;
  logic [15:0] o_digits;
  logic        o_valid;
  logic        o_err;

  int vectors     = 0;
  int miscompares = 0;
  int valid_cnt   = 0;
  int err_cnt     = 0;
  int valid_long  = 0;
  int err_long    = 0;
  logic valid_prev = 1'b0;
  logic err_prev   = 1'b0;
  int v0, e0;

  fnd_scan_decoder #(
    .SETTLE_CYCLES(4),
    .MATCH_SCANS  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_fnd_com (i_fnd_com),
    .i_fnd_data(i_fnd_data),
    .o_value   (o_value),
    .o_digits  (o_digits),
    .o_valid   (o_valid),
    .o_err     (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor: counts pulses and flags any pulse wider than one cycle
  always @(negedge clk) begin
    if (o_valid) valid_cnt <= valid_cnt + 1;
    if (o_err)   err_cnt   <= err_cnt + 1;
    if (o_valid && valid_prev) valid_long <= valid_long + 1;
    if (o_err && err_prev)     err_long   <= err_long + 1;
    valid_prev <= o_valid;
    err_prev   <= o_err;
  end

  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 8'hC0;
      4'd1: seg = 8'hF9;
      4'd2: seg = 8'hA4;
      4'd3: seg = 8'hB0;
      4'd4: seg = 8'h99;
      4'd5: seg = 8'h92;
      4'd6: seg = 8'h82;
      4'd7: seg = 8'hF8;
      4'd8: seg = 8'h80;
      4'd9: seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic show(input logic [3:0] com, input logic [7:0] data, input int dwell);
    i_fnd_com  = com;
    i_fnd_data = data;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic idle(input int n);
    show(4'b1111, 8'hFF, n);
  endtask

  // Ordered scan ones -> thousands
  task automatic scan(input logic [15:0] bcd, input int dwell);
    show(4'b1110, seg(bcd[3:0]),   dwell);
    show(4'b1101, seg(bcd[7:4]),   dwell);
    show(4'b1011, seg(bcd[11:8]),  dwell);
    show(4'b0111, seg(bcd[15:12]), dwell);
  endtask

  initial begin
    rst        = 1'b0;
    i_fnd_com  = 4'b1111;
    i_fnd_data = 8'hFF;
    repeat (3) @(negedge clk);
    check("reset_value",  32'(o_value),  32'd0);
    check("reset_digits", 32'(o_digits), 32'd0);
    check("reset_valid",  32'(o_valid),  32'd0);
    check("reset_err",    32'(o_err),    32'd0);
    rst = 1'b1;
    idle(4);

    // 1: steady 1234
    v0 = valid_cnt;
    scan(16'h1234, 8);
    idle(16);
    check("t1_first_scan_no_pulse", 32'(valid_cnt - v0), 32'd0);
    scan(16'h1234, 8);
    idle(16);
    check("t1_pulse_count", 32'(valid_cnt - v0), 32'd1);
    check("t1_value",  32'(o_value),  32'd1234);
    check("t1_digits", 32'(o_digits), 32'h1234);
    v0 = valid_cnt;
    for (int i = 0; i < 10; i++) scan(16'h1234, 8);
    idle(16);
    check("t1_steady_no_pulse", 32'(valid_cnt - v0), 32'd0);

    // 2: switch to 0007 then 9999
    v0 = valid_cnt;
    scan(16'h0007, 8);
    scan(16'h0007, 8);
    idle(16);
    check("t2_pulse_count", 32'(valid_cnt - v0), 32'd1);
    check("t2_value",  32'(o_value),  32'd7);
    check("t2_digits", 32'(o_digits), 32'h0007);
    scan(16'h9999, 8);
    scan(16'h9999, 8);
    idle(16);
    check("t2_value_9999",  32'(o_value),  32'h270F);
    check("t2_digits_9999", 32'(o_digits), 32'h9999);

    // 3: tens dwell too short, then normal dwell for 2468
    v0 = valid_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) begin
      show(4'b1110, seg(4'd8), 8);
      idle(2);
      show(4'b1101, seg(4'd6), 3);
      idle(2);
      show(4'b1011, seg(4'd4), 8);
      show(4'b0111, seg(4'd2), 8);
    end
    idle(16);
    check("t3_short_no_pulse", 32'(valid_cnt - v0), 32'd0);
    check("t3_short_no_err",   32'(err_cnt - e0),   32'd0);
    check("t3_short_value",    32'(o_value),        32'd9999);
    scan(16'h2468, 8);
    scan(16'h2468, 8);
    idle(16);
    check("t3_pulse_count", 32'(valid_cnt - v0), 32'd1);
    check("t3_value",       32'(o_value),        32'd2468);

    // 4: invalid hundreds pattern, then clean 4321
    v0 = valid_cnt;
    e0 = err_cnt;
    show(4'b1110, seg(4'd1), 8);
    show(4'b1101, seg(4'd2), 8);
    show(4'b1011, 8'h88,     8);
    show(4'b0111, seg(4'd4), 8);
    idle(16);
    check("t4_err_count",   32'(err_cnt - e0),   32'd1);
    check("t4_no_pulse",    32'(valid_cnt - v0), 32'd0);
    check("t4_value_held",  32'(o_value),        32'd2468);
    scan(16'h4321, 8);
    scan(16'h4321, 8);
    idle(16);
    check("t4_pulse_count", 32'(valid_cnt - v0), 32'd1);
    check("t4_value",       32'(o_value),        32'd4321);
    check("t4_digits",      32'(o_digits),       32'h4321);

    // 5: alternating scans never match, then unordered 5678
    v0 = valid_cnt;
    for (int i = 0; i < 3; i++) begin
      scan(16'h1234, 8);
      scan(16'h1235, 8);
    end
    idle(16);
    check("t5_alternate_no_pulse", 32'(valid_cnt - v0), 32'd0);
    for (int i = 0; i < 2; i++) begin
      show(4'b1101, seg(4'd7), 8);
      show(4'b0111, seg(4'd5), 8);
      show(4'b1110, seg(4'd8), 8);
      show(4'b1011, seg(4'd6), 8);
    end
    idle(16);
    check("t5_pulse_count", 32'(valid_cnt - v0), 32'd1);
    check("t5_value",       32'(o_value),        32'd5678);

    // 6: reset during conversion of 8080
    v0 = valid_cnt;
    scan(16'h8080, 8);
    show(4'b1110, seg(4'd0), 8);
    show(4'b1101, seg(4'd8), 8);
    show(4'b1011, seg(4'd0), 8);
    show(4'b0111, seg(4'd8), 7);
    rst        = 1'b0;
    i_fnd_com  = 4'b1111;
    i_fnd_data = 8'hFF;
    #1;
    check("t6_async_value",  32'(o_value),  32'd0);
    check("t6_async_digits", 32'(o_digits), 32'd0);
    check("t6_async_valid",  32'(o_valid),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(16);
    check("t6_aborted_no_pulse", 32'(valid_cnt - v0), 32'd0);
    scan(16'h8080, 8);
    idle(16);
    check("t6_one_scan_no_pulse", 32'(valid_cnt - v0), 32'd0);
    check("t6_one_scan_value",    32'(o_value),        32'd0);
    scan(16'h8080, 8);
    idle(16);
    check("t6_pulse_count", 32'(valid_cnt - v0), 32'd1);
    check("t6_value",       32'(o_value),        32'd8080);
    check("t6_digits",      32'(o_digits),       32'h8080);

    check("valid_one_cycle", 32'(valid_long), 32'd0);
    check("err_one_cycle",   32'(err_long),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
